// File: rtl/mic_pdm_ctrl_if.sv
// rtl/mic_pdm_ctrl_if.sv - Wishbone register bus between a CPU and mic_pdm_ctrl
interface mic_pdm_ctrl_if;
  logic       wb_we_i;
  logic [2:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic       wb_stb_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;

  modport master (
    output wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/mic_pdm_ctrl.sv
// rtl/mic_pdm_ctrl.sv - PDM mic pair sequencer: clock gen, ones-count decimation, FIFO, Wishbone regs
// Define MIC_PDM_STEREO_EN to add the right channel (rising-edge counter and CTRL stereo bit).
module mic_pdm_ctrl #(
  parameter int FifoDepth      = 4,
  parameter int StartupWindows = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mic_pdm_ctrl_if.slave        wb,
  output logic                 mic_clk_o,
  input  logic                 mic_data_i,
  output logic                 irq_o
);
  localparam int         PtrW    = $clog2(FifoDepth);
  localparam logic [3:0] WuLast  = 4'(StartupWindows == 0 ? 0 : StartupWindows - 1);
  localparam logic [3:0] FullLvl = 4'(FifoDepth);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
  state_t state, state_nx;

  logic       ctrl_en, ctrl_irq_en, ctrl_stereo;
  logic [7:0] div_reg, win_reg;
  logic       acc, wr, rd, flush;
  logic       running, in_warmup, in_run;

  // stb is ignored while ack is high, so each access costs two cycles
  assign acc   = wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr    = acc & wb.wb_we_i;
  assign rd    = acc & ~wb.wb_we_i;
  assign flush = wr && wb.wb_adr_i == 3'd0 && wb.wb_dat_i[4];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      div_reg     <= 8'd0;
      win_reg     <= 8'd0;
    end else if (wr) begin
      case (wb.wb_adr_i)
        3'd0: begin
          ctrl_en     <= wb.wb_dat_i[0];
          ctrl_irq_en <= wb.wb_dat_i[2];
        end
        3'd2:    div_reg <= wb.wb_dat_i;
        3'd3:    win_reg <= wb.wb_dat_i;
        default: ;
      endcase
    end
  end

  logic [7:0] div_cnt, div_lat, win_cnt, win_lat, cnt_l, l_next, r_byte;
  logic       tick, fall_tick, win_end;

  assign tick      = ctrl_en && div_cnt == div_lat;
  assign fall_tick = tick & mic_clk_o;
  assign win_end   = fall_tick && win_cnt == win_lat;
  assign l_next    = (cnt_l == 8'hFF) ? cnt_l : cnt_l + {7'd0, mic_data_i};

  // DIV and WINDOW are sampled only at toggles / window ends so a period is never cut short
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt   <= 8'd0;
      div_lat   <= 8'd0;
      mic_clk_o <= 1'b0;
      win_cnt   <= 8'd0;
      win_lat   <= 8'd0;
      cnt_l     <= 8'd0;
    end else if (!ctrl_en) begin
      div_cnt   <= 8'd0;
      div_lat   <= div_reg;
      mic_clk_o <= 1'b0;
      win_cnt   <= 8'd0;
      win_lat   <= win_reg;
      cnt_l     <= 8'd0;
    end else begin
      if (tick) begin
        div_cnt   <= 8'd0;
        div_lat   <= div_reg;
        mic_clk_o <= ~mic_clk_o;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (fall_tick) begin
        if (win_end) begin
          win_cnt <= 8'd0;
          win_lat <= win_reg;
          cnt_l   <= 8'd0;
        end else begin
          win_cnt <= win_cnt + 8'd1;
          cnt_l   <= l_next;
        end
      end
    end
  end

`ifdef MIC_PDM_STEREO_EN
  logic [7:0] cnt_r;
  logic       unused_wdat;
  assign unused_wdat = ^{wb.wb_dat_i[7:5], wb.wb_dat_i[3]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      ctrl_stereo <= 1'b0;
    else if (wr && wb.wb_adr_i == 3'd0)
      ctrl_stereo <= wb.wb_dat_i[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_r <= 8'd0;
    else if (!ctrl_en || win_end)
      cnt_r <= 8'd0;
    else if (tick && !mic_clk_o && ctrl_stereo && cnt_r != 8'hFF)
      cnt_r <= cnt_r + {7'd0, mic_data_i};
  end

  assign r_byte = ctrl_stereo ? cnt_r : 8'd0;
`else
  logic unused_wdat;
  assign unused_wdat = ^{wb.wb_dat_i[7:5], wb.wb_dat_i[3], wb.wb_dat_i[1]};
  assign ctrl_stereo = 1'b0;
  assign r_byte      = 8'd0;
`endif

  logic [3:0] wu_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ctrl_en) state_nx = (StartupWindows == 0) ? RUN : WARMUP;
      WARMUP:  if (win_end && wu_cnt == WuLast) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = IDLE;
    endcase
    if (!ctrl_en) state_nx = IDLE;
  end

  always_comb begin
    running   = state != IDLE;
    in_warmup = state == WARMUP;
    in_run    = state == RUN;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        wu_cnt <= 4'd0;
    else if (!in_warmup) wu_cnt <= 4'd0;
    else if (win_end)   wu_cnt <= wu_cnt + 4'd1;
  end

  logic [15:0]     mem [FifoDepth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [3:0]      level;
  logic            ovf, full, nonempty, push, pop, do_push;
  logic [15:0]     head;

  assign full     = level == FullLvl;
  assign nonempty = level != 4'd0;
  assign head     = mem[rd_ptr];
  assign push     = in_run & win_end;
  assign pop      = nonempty && rd &&
                    ((wb.wb_adr_i == 3'd4 && !ctrl_stereo) || wb.wb_adr_i == 3'd5);
  assign do_push  = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= {r_byte, l_next};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 4'd0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 4'd0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)     rd_ptr <= rd_ptr + PtrW'(1);
      if (push && !do_push) ovf <= 1'b1;
      level <= level + {3'd0, do_push} - {3'd0, pop};
    end
  end

  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    case (wb.wb_adr_i)
      3'd0:    rd_mux = {5'd0, ctrl_irq_en, ctrl_stereo, ctrl_en};
      3'd1:    rd_mux = {level, running, ovf, full, nonempty};
      3'd2:    rd_mux = div_reg;
      3'd3:    rd_mux = win_reg;
      3'd4:    rd_mux = nonempty ? head[7:0] : 8'h00;
      3'd5:    rd_mux = (nonempty && ctrl_stereo) ? head[15:8] : 8'h00;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 8'h00;
      irq_o       <= 1'b0;
    end else begin
      wb.wb_ack_o <= acc;
      wb.wb_dat_o <= rd ? rd_mux : 8'h00;
      irq_o       <= ctrl_irq_en & (nonempty | ovf);
    end
  end
endmodule

// File: doc/mic_pdm_ctrl.md
# mic_pdm_ctrl

Wishbone-controlled sequencer for a pair of PDM MEMS microphones sharing one data line. It generates the microphone clock and decimates each channel by counting ones over a programmable window of microphone clock periods. Left is sampled on mic-clock falling edges and right on rising edges. Results pass through a FIFO that the CPU drains over the 8-bit Wishbone bus, with an interrupt on data or overflow.

## Interface
- `FifoDepth`, 4: FIFO entries, each {right, left} 8-bit; power of two, 2..8.
- `StartupWindows`, 2: windows discarded after enable (mic wake-up), 0..15.
- `clk_i` in 1: sole clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `wb_we_i` in 1: write strobe.
- `wb_adr_i` in 3: register address.
- `wb_dat_i` in 8: write data.
- `wb_stb_i` in 1: request; held until ack.
- `wb_dat_o` out 8: read data, registered.
- `wb_ack_o` out 1: one-cycle acknowledge.
- `mic_clk_o` out 1: microphone clock.
- `mic_data_i` in 1: shared PDM data line.
- `irq_o` out 1: level interrupt.

## Operation
- Registers:
  - 0 CTRL, R/W: bit0 enable, bit1 stereo, bit2 irq_en. Writing bit4=1 flushes the FIFO and clears overflow (self-clearing, reads 0).
  - 1 STATUS, RO: bit0 nonempty, bit1 full, bit2 overflow (sticky), bit3 running, bits7:4 level.
  - 2 DIV, R/W: mic_clk_o toggles every DIV+1 clk_i cycles. Reset 0.
  - 3 WINDOW, R/W: window is WINDOW+1 mic periods. Reset 0.
  - 4 DATA_L, RO: head left byte; pops only when stereo=0.
  - 5 DATA_R, RO: head right byte; always pops. Reads 0 in mono.
  - 6, 7: read 0; writes ignored.
  - Reading DATA_L or DATA_R when the FIFO is empty returns 0 and does not pop.
- State machine:
  - IDLE: mic_clk_o=0, counters 0. Goes to WARMUP when enable=1.
  - WARMUP: clock runs, windows are counted, nothing is pushed. Goes to RUN after StartupWindows windows complete, or immediately if StartupWindows=0.
  - Any state: enable=0 returns to IDLE next cycle; partial window discarded; FIFO contents kept.
- Sampling:
  - Edge cycle = the clk_i cycle on which mic_clk_o toggles.
  - At a 1→0 toggle, mic_data_i increments the left count. At a 0→1 toggle, it increments the right count (stereo only).
  - Counts saturate at 255.
  - The window ends at the falling toggle completing period WINDOW+1. In RUN, {R,L} is pushed that cycle, counts restart at 0, and WINDOW is re-latched.
  - DIV changes apply at the next toggle.
- FIFO:
  - Push when full without a same-cycle pop: entry dropped, overflow set.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Flush in the same cycle as a push: flush wins, FIFO empty.
- irq_o = irq_en & (nonempty | overflow), registered.

## Timing
- Reset values: wb_dat_o=0, wb_ack_o=0, mic_clk_o=0, irq_o=0. FIFO empty, all registers 0, state IDLE.
- Wishbone handshake:
  - wb_ack_o is asserted the cycle after wb_stb_i rises, for one cycle.
  - wb_stb_i is ignored during the ack cycle, so back-to-back accesses take 2 cycles each.
  - The write or pop takes effect on the ack cycle. Read data is valid with ack.
- Enable latency: the first mic_clk_o rise occurs DIV+1 cycles after the CTRL write ack.
- Push latency: the FIFO level increments the cycle after the window-ending edge cycle.
- irq_o follows the status change by one cycle.
- Asynchronous reset mid-window or mid-transaction returns everything to reset values; the interrupted Wishbone access is not acked.

## Configuration
- `MIC_PDM_STEREO_EN` defined:
  - Right-channel counter, rising-edge sampling and the CTRL stereo bit are present.
- Not defined:
  - CTRL bit1 reads 0 and ignores writes.
  - Right byte is stored as 0.
  - DATA_R reads 0 but still pops.
  - DATA_L pops.
  - No right-channel logic is synthesized.

## Test plan
- Reset: hold rst_ni=0 with wb_stb_i=1 → all outputs 0, no ack, mic_clk_o=0.
- Mono window count:
  - Setup: DIV=0, WINDOW=3, StartupWindows=2, mic_data_i=1, enable.
  - Expected: first push about 24 cycles after enable; DATA_L read returns 4 and pops; level goes 1→0.
- Stereo (macro defined):
  - Setup: stereo=1, mic_data_i driven 1 only around falling edges.
  - Expected: DATA_L=WINDOW+1, DATA_R=0. Reading DATA_L leaves level unchanged; reading DATA_R decrements it.
- Overflow:
  - Setup: FifoDepth=4, no reads for 6 windows.
  - Expected: level=4, full=1, overflow=1, irq_o=1 with irq_en=1.
  - Then: CTRL write with bit4=1 → level 0, overflow 0, irq_o=0 one cycle later.
- Saturation: WINDOW=255, mic_data_i=1 → DATA_L=255.
- Disable mid-window: clear enable halfway through a window → mic_clk_o=0 next cycle, no push. On re-enable, WARMUP repeats.
